pure_literal_scan: RTL and testbench

- Parametrised pure-literal finder for the DPLL datapath; successor to the single-result pure-literal finder.
- Scans a formula under a partial assignment, skipping satisfied clauses and assigned variables, and examines LANES literals per cycle.
- Streams every pure literal found, or only the first, over a valid/ready port. Reports a count and a completion pulse.
- Sits between the unit-propagation stage and the decision/branch controller.

---
 rtl/pure_literal_scan_pkg.sv | 47 ++++
 rtl/pure_literal_scan_clause_sat_check.sv | 24 ++
 rtl/pure_literal_scan.sv | 222 ++++++++++++++++++++++
 tb/tb_pure_literal_scan.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pure_literal_scan_pkg.sv
// Shared formula/clause/literal types for the DPLL datapath, plus the
// pure-literal scanner state type and small literal helpers.
package pure_literal_scan_pkg;

  localparam int number_literal    = 8;  // variables x1..x8
  localparam int width_clausearray = 4;  // max clauses per formula
  localparam int width_litarray    = 6;  // max literals per clause

  localparam int LIT_NUM_W = 4;
  localparam int VAR_IDX_W = $clog2(number_literal);
  localparam int CLEN_W    = $clog2(width_litarray + 1);
  localparam int FLEN_W    = $clog2(width_clausearray + 1);
  localparam int CNT_W     = $clog2(number_literal + 1);

  // num is 1-based; 0 and values above number_literal are "no variable"
  typedef struct packed {
    logic [LIT_NUM_W-1:0] num;
    logic                 val;
  } lit;

  typedef struct packed {
    logic [CLEN_W-1:0]            len;
    lit [width_litarray-1:0]      lits;
  } clause;

  typedef struct packed {
    logic [FLEN_W-1:0]            len;
    clause [width_clausearray-1:0] clauses;
  } formula;

  localparam lit zero_lit = '0;

  typedef logic [CNT_W-1:0] pure_cnt_t;

  typedef enum logic [2:0] {IDLE, CHK, SCAN, EMIT, FIN} pls_state_t;

  // True when num names a real variable.
  function automatic logic num_in_range(input logic [LIT_NUM_W-1:0] num);
    return (num != '0) && (num <= LIT_NUM_W'(number_literal));
  endfunction

  // Zero-based bit position of a literal's variable (only meaningful in range).
  function automatic logic [VAR_IDX_W-1:0] var_idx(input logic [LIT_NUM_W-1:0] num);
    return VAR_IDX_W'(num - LIT_NUM_W'(1));
  endfunction

endpackage

// File: rtl/pure_literal_scan_clause_sat_check.sv
// Combinational test: is a clause satisfied by the partial assignment?
// Literals past the clause length and out-of-range variables never satisfy.
module clause_sat_check
  import pure_literal_scan_pkg::*;
(
  input  clause                     in_clause,
  input  logic [number_literal-1:0] assign_set,
  input  logic [number_literal-1:0] assign_val,
  output logic                      sat
);

  logic [width_litarray-1:0] lit_sat;

  for (genvar gi = 0; gi < width_litarray; gi++) begin : g_lit
    lit cur;
    assign cur = in_clause.lits[gi];
    assign lit_sat[gi] = (CLEN_W'(gi) < in_clause.len) && num_in_range(cur.num) &&
                         assign_set[var_idx(cur.num)] &&
                         (assign_val[var_idx(cur.num)] == cur.val);
  end

  assign sat = |lit_sat;

endmodule

// File: rtl/pure_literal_scan.sv
// Pure-literal finder: walks the clauses of a latched formula, records which
// polarities of each unassigned variable occur, then streams the pure ones.
module pure_literal_scan
  import pure_literal_scan_pkg::*;
#(
  parameter int LANES    = 1,
  parameter bit SKIP_SAT = 1'b1,
  parameter bit EMIT_ALL = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  formula                    in_formula,
  input  logic [number_literal-1:0] assign_set,
  input  logic [number_literal-1:0] assign_val,
  output logic                      busy,
  output logic                      lit_valid,
  input  logic                      lit_ready,
  output lit                        lit_out,
  output logic                      done,
  output logic                      found,
  output pure_cnt_t                 pure_count
);

  localparam int K_W    = $clog2(width_litarray + LANES + 1);
  localparam int CIDX_W = $clog2(width_clausearray);
  localparam int LIDX_W = $clog2(width_litarray);

  typedef logic [number_literal-1:0] var_vec_t;

  pls_state_t        state_reg, state_next;
  formula            formula_reg, formula_next;
  var_vec_t          set_reg, set_next, val_reg, val_next;
  var_vec_t          seen_pos_reg, seen_pos_next, seen_neg_reg, seen_neg_next;
  logic [FLEN_W-1:0] c_reg, c_next;
  logic [K_W-1:0]    k_reg, k_next;
  logic [CNT_W-1:0]  p_reg, p_next;
  logic              valid_reg, valid_next;
  lit                lit_reg, lit_next;
  logic              found_reg, found_next;
  pure_cnt_t         count_reg, count_next;

  // Oversized lengths are clamped to the storage actually present.
  logic [FLEN_W-1:0] start_len;
  assign start_len = (in_formula.len > FLEN_W'(width_clausearray)) ?
                     FLEN_W'(width_clausearray) : in_formula.len;

  clause             cur_clause;
  logic [CLEN_W-1:0] clen;
  logic              clause_sat;
  assign cur_clause = formula_reg.clauses[CIDX_W'(c_reg)];
  assign clen = (cur_clause.len > CLEN_W'(width_litarray)) ?
                CLEN_W'(width_litarray) : cur_clause.len;

  clause_sat_check u_sat (
    .in_clause  (cur_clause),
    .assign_set (set_reg),
    .assign_val (val_reg),
    .sat        (clause_sat)
  );

  // Each lane turns its literal into a one-hot polarity mark.
  var_vec_t lane_pos [LANES];
  var_vec_t lane_neg [LANES];
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [K_W-1:0] idx;
    lit             lane_lit;
    logic           hit;
    assign idx      = k_reg + K_W'(gi);
    assign lane_lit = (idx < K_W'(width_litarray)) ? cur_clause.lits[LIDX_W'(idx)] : zero_lit;
    assign hit      = (idx < K_W'(clen)) && num_in_range(lane_lit.num) &&
                      !set_reg[var_idx(lane_lit.num)];
    assign lane_pos[gi] = (hit && lane_lit.val)  ? (var_vec_t'(1) << var_idx(lane_lit.num)) : '0;
    assign lane_neg[gi] = (hit && !lane_lit.val) ? (var_vec_t'(1) << var_idx(lane_lit.num)) : '0;
  end

  var_vec_t scan_pos, scan_neg;
  // OR all lanes together so duplicate variables in one beat simply merge.
  always_comb begin
    scan_pos = '0;
    scan_neg = '0;
    for (int i = 0; i < LANES; i++) begin
      scan_pos = scan_pos | lane_pos[i];
      scan_neg = scan_neg | lane_neg[i];
    end
  end

  logic [VAR_IDX_W-1:0] pidx;
  logic skip_clause, scan_last, clause_last, var_last, pure_here;
  assign pidx        = VAR_IDX_W'(p_reg);
  assign skip_clause = (clen == '0) || (SKIP_SAT && clause_sat);
  assign scan_last   = (k_reg + K_W'(LANES)) >= K_W'(clen);
  assign clause_last = (c_reg + FLEN_W'(1)) == formula_reg.len;
  assign var_last    = (p_reg == CNT_W'(number_literal - 1));
  assign pure_here   = (seen_pos_reg[pidx] ^ seen_neg_reg[pidx]) & ~set_reg[pidx];

  // Next-state and datapath updates for the scan sequence.
  always_comb begin
    state_next    = state_reg;
    formula_next  = formula_reg;
    set_next      = set_reg;
    val_next      = val_reg;
    seen_pos_next = seen_pos_reg;
    seen_neg_next = seen_neg_reg;
    c_next        = c_reg;
    k_next        = k_reg;
    p_next        = p_reg;
    valid_next    = valid_reg;
    lit_next      = lit_reg;
    found_next    = found_reg;
    count_next    = count_reg;

    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      valid_next = 1'b0;
      lit_next   = zero_lit;
      found_next = 1'b0;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            formula_next     = in_formula;
            formula_next.len = start_len;
            set_next         = assign_set;
            val_next         = assign_val;
            seen_pos_next    = '0;
            seen_neg_next    = '0;
            found_next       = 1'b0;
            count_next       = '0;
            c_next           = '0;
            k_next           = '0;
            p_next           = '0;
            state_next       = (start_len == '0) ? EMIT : CHK;
          end
        end
        CHK: begin
          if (skip_clause) begin
            c_next     = c_reg + FLEN_W'(1);
            state_next = clause_last ? EMIT : CHK;
          end else begin
            k_next     = '0;
            state_next = SCAN;
          end
        end
        SCAN: begin
          seen_pos_next = seen_pos_reg | scan_pos;
          seen_neg_next = seen_neg_reg | scan_neg;
          if (scan_last) begin
            c_next     = c_reg + FLEN_W'(1);
            state_next = clause_last ? EMIT : CHK;
          end else begin
            k_next = k_reg + K_W'(LANES);
          end
        end
        EMIT: begin
          if (valid_reg) begin
            if (lit_ready) begin
              valid_next = 1'b0;
              count_next = count_reg + CNT_W'(1);
              found_next = 1'b1;
              if (!EMIT_ALL || var_last) state_next = FIN;
              else p_next = p_reg + CNT_W'(1);
            end
          end else if (pure_here) begin
            valid_next   = 1'b1;
            lit_next.num = LIT_NUM_W'(p_reg) + LIT_NUM_W'(1);
            lit_next.val = seen_pos_reg[pidx];
          end else if (var_last) begin
            state_next = FIN;
          end else begin
            p_next = p_reg + CNT_W'(1);
          end
        end
        FIN: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      formula_reg  <= '0;
      set_reg      <= '0;
      val_reg      <= '0;
      seen_pos_reg <= '0;
      seen_neg_reg <= '0;
      c_reg        <= '0;
      k_reg        <= '0;
      p_reg        <= '0;
      valid_reg    <= 1'b0;
      lit_reg      <= zero_lit;
      found_reg    <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      formula_reg  <= formula_next;
      set_reg      <= set_next;
      val_reg      <= val_next;
      seen_pos_reg <= seen_pos_next;
      seen_neg_reg <= seen_neg_next;
      c_reg        <= c_next;
      k_reg        <= k_next;
      p_reg        <= p_next;
      valid_reg    <= valid_next;
      lit_reg      <= lit_next;
      found_reg    <= found_next;
      count_reg    <= count_next;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == FIN);
  assign lit_valid  = valid_reg;
  assign lit_out    = lit_reg;
  assign found      = found_reg;
  assign pure_count = count_reg;

endmodule

// File: tb/tb_pure_literal_scan.sv
// Bench for pure_literal_scan: two instances (LANES=1/skip/all and
// LANES=4/no-skip/first-only) share stimulus; results are compared with a
// clause-by-clause reference model of the pure-literal rules.
module tb_pure_literal_scan;
  import pure_literal_scan_pkg::*;

  logic clock = 1'b0;
  logic reset, start, abort, lit_ready;
  formula in_formula;
  logic [number_literal-1:0] assign_set, assign_val;

  logic a_busy, a_valid, a_done, a_found;
  lit a_lit;
  pure_cnt_t a_count;
  logic b_busy, b_valid, b_done, b_found;
  lit b_lit;
  pure_cnt_t b_count;

  int checks = 0;
  int errors = 0;

  string got_a, got_b;
  int lat_a, lat_b, done_a, done_b, cnt_a, cnt_b, fnd_a, fnd_b;
  bit timed_out;
  formula tf;

  always #5 clock = ~clock;

  pure_literal_scan #(.LANES(1), .SKIP_SAT(1'b1), .EMIT_ALL(1'b1)) dut_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .in_formula(in_formula), .assign_set(assign_set), .assign_val(assign_val),
    .busy(a_busy), .lit_valid(a_valid), .lit_ready(lit_ready), .lit_out(a_lit),
    .done(a_done), .found(a_found), .pure_count(a_count));

  pure_literal_scan #(.LANES(4), .SKIP_SAT(1'b0), .EMIT_ALL(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .in_formula(in_formula), .assign_set(assign_set), .assign_val(assign_val),
    .busy(b_busy), .lit_valid(b_valid), .lit_ready(lit_ready), .lit_out(b_lit),
    .done(b_done), .found(b_found), .pure_count(b_count));

  function automatic lit mk(input int l);
    lit r;
    r.num = LIT_NUM_W'(l < 0 ? -l : l);
    r.val = (l > 0);
    return r;
  endfunction

  function automatic string fmt(input string st, input int n, input int fnd,
                                input int d, input int lat, input bit with_lat);
    if (with_lat) return $sformatf("[%s] n=%0d f=%0d d=%0d lat=%0d", st, n, fnd, d, lat);
    return $sformatf("[%s] n=%0d f=%0d d=%0d", st, n, fnd, d);
  endfunction

  function automatic string res_a(input bit with_lat);
    return fmt(got_a, cnt_a, fnd_a, timed_out ? -1 : done_a, lat_a, with_lat);
  endfunction

  function automatic string res_b(input bit with_lat);
    return fmt(got_b, cnt_b, fnd_b, timed_out ? -1 : done_b, lat_b, with_lat);
  endfunction

  // Reference: collect polarities of unassigned variables in non-skipped
  // clauses, list the one-sided ones, and total the cycle cost.
  task automatic model(input formula f, input logic [7:0] s, input logic [7:0] v,
                       input bit skip, input int lanes, input bit emit_all,
                       input bit with_lat, output string res);
    bit pos [1:8];
    bit neg [1:8];
    int lat, n_pure, first, len, n;
    bit sat;
    string str;
    lat = 0; n_pure = 0; first = 0; str = "";
    for (int i = 1; i <= 8; i++) begin pos[i] = 0; neg[i] = 0; end
    for (int c = 0; c < int'(f.len); c++) begin
      len = int'(f.clauses[c].len);
      sat = 0;
      for (int j = 0; j < len; j++) begin
        n = int'(f.clauses[c].lits[j].num);
        if (n >= 1 && n <= 8 && s[n-1] && v[n-1] == f.clauses[c].lits[j].val) sat = 1;
      end
      lat++;
      if (len == 0 || (skip && sat)) continue;
      lat += (len + lanes - 1) / lanes;
      for (int j = 0; j < len; j++) begin
        n = int'(f.clauses[c].lits[j].num);
        if (n >= 1 && n <= 8 && !s[n-1]) begin
          if (f.clauses[c].lits[j].val) pos[n] = 1;
          else neg[n] = 1;
        end
      end
    end
    for (int i = 1; i <= 8; i++) begin
      if (pos[i] != neg[i] && !s[i-1] && (emit_all || n_pure == 0)) begin
        str = {str, $sformatf("{%0d,%0d}", i, pos[i])};
        n_pure++;
        if (n_pure == 1) first = i;
      end
    end
    if (!emit_all && n_pure > 0) lat += first + 1;
    else lat += 8 + n_pure;
    lat++;
    res = fmt(str, n_pure, (n_pure > 0) ? 1 : 0, 1, lat, with_lat);
  endtask

  task automatic load_f1();
    tf = '0;
    tf.len = 3'd3;
    tf.clauses[0].len = 3'd2; tf.clauses[0].lits[0] = mk(1);  tf.clauses[0].lits[1] = mk(-2);
    tf.clauses[1].len = 3'd2; tf.clauses[1].lits[0] = mk(1);  tf.clauses[1].lits[1] = mk(3);
    tf.clauses[2].len = 3'd2; tf.clauses[2].lits[0] = mk(-2); tf.clauses[2].lits[1] = mk(-3);
    in_formula = tf;
    assign_set = '0;
    assign_val = '0;
  endtask

  // Pulse start for one cycle; returns at the negedge after acceptance.
  task automatic start_scan();
    got_a = ""; got_b = ""; lat_a = 0; lat_b = 0; done_a = 0; done_b = 0;
    cnt_a = 0; cnt_b = 0; fnd_a = 0; fnd_b = 0; timed_out = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Run both instances to completion, recording handshakes, done, latency.
  task automatic collect(input int ready_pct);
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      lit_ready = ($urandom_range(99) < ready_pct);
      if (a_busy) lat_a++;
      if (b_busy) lat_b++;
      if (a_valid && lit_ready) got_a = {got_a, $sformatf("{%0d,%0d}", a_lit.num, a_lit.val)};
      if (b_valid && lit_ready) got_b = {got_b, $sformatf("{%0d,%0d}", b_lit.num, b_lit.val)};
      if (a_done) begin done_a++; fnd_a = (a_found === 1'b1); cnt_a = int'(a_count); end
      if (b_done) begin done_b++; fnd_b = (b_found === 1'b1); cnt_b = int'(b_count); end
      if (!a_busy && !b_busy) begin timed_out = 1'b0; break; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    checks++;
    if ({a_busy, a_valid, a_done, a_found, a_count, a_lit, b_busy, b_valid, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a busy=%b valid=%b done=%b found=%b count=%0d lit=%h b busy=%b, need all 0",
               a_busy, a_valid, a_done, a_found, a_count, a_lit, b_busy);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({a_busy, b_busy, a_done, b_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy a=%b b=%b done a=%b b=%b, need 0", a_busy, b_busy, a_done, b_done);
    end
    $display("scan reset: outputs idle after reset");
  endtask

  task automatic test_directed(input string name, input string exp_a, input string exp_b);
    start_scan();
    collect(100);
    $display("scan %s: a=%s b=%s", name, res_a(1), res_b(1));
    checks++;
    if (res_a(1) != exp_a) begin
      errors++; $display("FAIL %s_a: got %s need %s", name, res_a(1), exp_a);
    end
    checks++;
    if (res_b(1) != exp_b) begin
      errors++; $display("FAIL %s_b: got %s need %s", name, res_b(1), exp_b);
    end
  endtask

  task automatic test_basic_stream();
    load_f1();
    test_directed("basic", fmt("{1,1}{2,0}", 2, 1, 1, 20, 1), fmt("{1,1}", 1, 1, 1, 9, 1));
  endtask

  task automatic test_skip_sat();
    load_f1();
    assign_set = 8'h01; assign_val = 8'h01;
    test_directed("skip_sat", fmt("{2,0}{3,0}", 2, 1, 1, 16, 1), fmt("{2,0}", 1, 1, 1, 10, 1));
  endtask

  task automatic test_no_pure();
    tf = '0;
    tf.len = 3'd2;
    tf.clauses[0].len = 3'd1; tf.clauses[0].lits[0] = mk(1);
    tf.clauses[1].len = 3'd1; tf.clauses[1].lits[0] = mk(-1);
    in_formula = tf; assign_set = '0; assign_val = '0;
    test_directed("no_pure", fmt("", 0, 0, 1, 13, 1), fmt("", 0, 0, 1, 13, 1));
  endtask

  task automatic test_lanes();
    tf = '0;
    tf.len = 3'd1;
    tf.clauses[0].len = 3'd5;
    tf.clauses[0].lits[0] = mk(2); tf.clauses[0].lits[1] = mk(-2); tf.clauses[0].lits[2] = mk(2);
    tf.clauses[0].lits[3] = mk(5); tf.clauses[0].lits[4] = mk(5);
    in_formula = tf; assign_set = '0; assign_val = '0;
    test_directed("lanes", fmt("{5,1}", 1, 1, 1, 16, 1), fmt("{5,1}", 1, 1, 1, 10, 1));
  endtask

  task automatic test_stall();
    lit exp_l;
    exp_l.num = 4'd1; exp_l.val = 1'b1;
    load_f1();
    lit_ready = 1'b0;
    start_scan();
    for (int i = 0; i < 100 && !a_valid; i++) @(negedge clock);
    checks++;
    if (a_valid !== 1'b1) begin
      errors++; $display("FAIL stall_wait: lit_valid=%b, need 1 within 100 cycles", a_valid);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      checks++;
      if (a_valid !== 1'b1 || a_lit !== exp_l) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid=%b lit={%0d,%0d}, need valid=1 lit={1,1}",
                 i, a_valid, a_lit.num, a_lit.val);
      end
      @(negedge clock);
    end
    start = 1'b0;
    collect(100);
    $display("scan stall: a=%s b=%s", res_a(0), res_b(0));
    checks++;
    if (res_a(0) != fmt("{1,1}{2,0}", 2, 1, 1, 0, 0)) begin
      errors++; $display("FAIL stall_a: got %s need %s", res_a(0), fmt("{1,1}{2,0}", 2, 1, 1, 0, 0));
    end
    checks++;
    if (res_b(0) != fmt("{1,1}", 1, 1, 1, 0, 0)) begin
      errors++; $display("FAIL stall_b: got %s need %s", res_b(0), fmt("{1,1}", 1, 1, 1, 0, 0));
    end
  endtask

  task automatic test_abort();
    int dn;
    load_f1();
    lit_ready = 1'b1;
    start_scan();
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if ({a_busy, b_busy, a_valid, b_valid, a_found, a_count} !== '0) begin
      errors++;
      $display("FAIL abort_scan: got busy a=%b b=%b valid a=%b b=%b found=%b count=%0d, need 0",
               a_busy, b_busy, a_valid, b_valid, a_found, a_count);
    end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_done || b_done) dn++;
      @(negedge clock);
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done cycles need 0", dn);
    end
    $display("scan abort: aborted in SCAN");
    test_directed("after_abort", fmt("{1,1}{2,0}", 2, 1, 1, 20, 1), fmt("{1,1}", 1, 1, 1, 9, 1));
    // abort after the first literal was delivered clears found and count
    start_scan();
    for (int i = 0; i < 60 && a_found !== 1'b1; i++) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if ({a_busy, a_found, a_count, a_valid} !== '0) begin
      errors++;
      $display("FAIL abort_emit: got busy=%b found=%b count=%0d valid=%b, need 0", a_busy, a_found, a_count, a_valid);
    end
    $display("scan abort: aborted in EMIT");
  endtask

  task automatic test_start_abort_idle();
    int dn;
    load_f1();
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_busy || b_busy || a_done || b_done) dn++;
      @(negedge clock);
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL start_abort_idle: got %0d active cycles need 0", dn);
    end
    $display("scan start_abort: no scan started");
  endtask

  task automatic test_reset_mid_scan();
    load_f1();
    lit_ready = 1'b1;
    start_scan();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_valid, a_found, a_count, a_lit, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: got busy=%b valid=%b found=%b count=%0d lit=%h b_busy=%b before next edge, need 0",
               a_busy, a_valid, a_found, a_count, a_lit, b_busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("scan reset_mid: reset applied during SCAN");
  endtask

  task automatic test_random();
    string ea, eb;
    int pct;
    bit wl;
    for (int it = 0; it < 40; it++) begin
      tf = '0;
      tf.len = FLEN_W'($urandom_range(0, 4));
      for (int c = 0; c < 4; c++) begin
        tf.clauses[c].len = CLEN_W'($urandom_range(0, 6));
        for (int j = 0; j < 6; j++) begin
          tf.clauses[c].lits[j].num = LIT_NUM_W'($urandom_range(0, 10));
          tf.clauses[c].lits[j].val = 1'($urandom_range(0, 1));
        end
      end
      in_formula = tf;
      assign_set = 8'($urandom) & 8'($urandom);
      assign_val = 8'($urandom);
      wl  = (it % 2 == 0);
      pct = wl ? 100 : int'($urandom_range(30, 90));
      model(tf, assign_set, assign_val, 1'b1, 1, 1'b1, wl, ea);
      model(tf, assign_set, assign_val, 1'b0, 4, 1'b0, wl, eb);
      start_scan();
      collect(pct);
      $display("scan random%0d: a=%s b=%s", it, res_a(wl), res_b(wl));
      checks++;
      if (res_a(wl) != ea) begin
        errors++; $display("FAIL random%0d_a: got %s need %s", it, res_a(wl), ea);
      end
      checks++;
      if (res_b(wl) != eb) begin
        errors++; $display("FAIL random%0d_b: got %s need %s", it, res_b(wl), eb);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; lit_ready = 1'b0;
    in_formula = '0; assign_set = '0; assign_val = '0;
    test_reset();
    test_basic_stream();
    test_skip_sat();
    test_no_pure();
    test_lanes();
    test_stall();
    test_abort();
    test_start_abort_idle();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
